dmem_controller: RTL and testbench
==================================

# dmem_controller

Responder-side data-memory controller for the GPU core. It accepts load/store requests from the LSU over a valid/ready request channel and models a fixed multi-cycle memory access. It returns one response per request (read data or write acknowledge) over a valid/ready response channel. It replaces the single-cycle combinational data memory path with a handshaked, latency-bearing memory so the core can be stalled on memory.

## Interface
Parameters:
- ADDR_W, 8: word-address bits backed by storage; DEPTH = 2**ADDR_W words.
- DATA_W, 16: data word width.
- LATENCY, 2: access cycles between request acceptance and response; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  LSU presents a request.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  16  word address, as produced by the ALU.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  LSU accepts the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_we  out  1  echo of the req_we of the request being answered.
- rsp_err  out  1  request address was out of range.
- busy  out  1  high in WAIT or RESP.

## Operation
- FSM states and transitions:
  - IDLE: req_ready = 1. On req_valid, latch we, addr and wdata, load the wait counter with LATENCY-1, and go to WAIT.
  - WAIT: req_ready = 0. Decrement the counter each cycle. When the counter is 0, perform the access and go to RESP.
  - RESP: rsp_valid = 1. rsp_rdata, rsp_we and rsp_err are held stable until rsp_ready. On rsp_ready, go to IDLE.
- Only one request is outstanding at a time. There is no request buffering and no IDLE bypass.
- Address range check:
  - Out of range when req_addr[15:ADDR_W] != 0. For ADDR_W = 16 the check is always false.
  - An out-of-range access writes nothing and returns rsp_err = 1 with rsp_rdata = 0.
- Store: mem[addr] <= wdata on the WAIT→RESP edge. Response carries rsp_rdata = 0 and rsp_we = 1.
- Load: rsp_rdata <= mem[addr] on the WAIT→RESP edge. The captured value reflects every prior store.
- Request inputs are sampled only at the acceptance edge. Changes while busy are ignored.
- rsp_ready is ignored outside RESP.
- Storage is cleared to 0 on reset.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_we = 0, rsp_err = 0, busy = 0.
  - All memory words = 0.
- Acceptance happens at an edge where state = IDLE and req_valid = 1. Call that edge E.
- rsp_valid rises after edge E + LATENCY, and the store commits at that same edge.
- LATENCY = 1 means exactly one WAIT cycle.
- When the response handshake completes at edge H, req_ready rises after H. The earliest next acceptance is edge H+1.
- Peak throughput is one request per LATENCY+2 cycles.
- Backpressure: rsp_valid and all response data stay constant for as long as rsp_ready = 0, with no limit on duration.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and drives the reset output values.
  - A store still in WAIT is not committed.
  - A response pending in RESP is dropped.
- All outputs are registered or decoded from state only. There is no combinational path from req_* to rsp_*, or from rsp_ready to req_ready.

## Test plan
- Reset, then store 0xBEEF to addr 5 (LATENCY = 2), accepted at edge 0:
  - rsp_valid rises after edge 2, with rsp_we = 1, rsp_err = 0, rsp_rdata = 0.
  - A load of addr 5 afterwards returns 0xBEEF.
- Load of addr 7 after reset → rsp_rdata = 0x0000, rsp_err = 0.
- Backpressure: load with rsp_ready held 0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready stays 0 throughout. Then assert rsp_ready → req_ready is 1 on the next cycle.
- Out-of-range store of 0x1234 to addr 0x0100 (ADDR_W = 8):
  - Response has rsp_err = 1.
  - A following load of addr 0x0000 still returns 0 (no aliasing).
- Reset pulse during WAIT of a store of 0xAAAA to addr 3 → outputs go to reset values, and a later load of addr 3 returns 0.
- Back-to-back: req_valid held high with 3 stores (addr 1..3, data 0x11..0x33) and rsp_ready tied 1 → acceptances occur every 4 cycles (LATENCY = 2). Loads then return 0x11, 0x22, 0x33.

Source files
------------

// File: rtl/dmem_controller.sv
// Handshaked data-memory responder: one outstanding load/store, fixed access latency,
// zero-cleared storage, and an out-of-range flag for addresses beyond the backed depth.
module dmem_controller #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_we,
  output logic              rsp_err,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_reg;
  logic [3:0]          cnt_reg;
  logic                we_reg;
  logic                err_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                req_ready_reg;
  logic                rsp_valid_reg;
  logic                busy_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic                rsp_we_reg;
  logic                rsp_err_reg;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                req_oor;
  logic                access_now;
  logic                mem_wr;

  // Upper address bits above the backed range must be zero, otherwise the access is rejected.
  generate
    if (ADDR_W < 16) begin : g_range_chk
      assign req_oor = |req_addr[15:ADDR_W];
    end else begin : g_no_range_chk
      assign req_oor = 1'b0;
    end
  endgenerate

  assign access_now = (state_reg == WAIT) && (cnt_reg == 4'd0);
  assign mem_wr     = access_now && we_reg && !err_reg;

  // Storage must read back as zero after reset, so it is a cleared register array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_wr) begin
      mem[addr_reg] <= wdata_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      err_reg       <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_we_reg    <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg        <= req_we;
            err_reg       <= req_oor;
            addr_reg      <= req_addr[ADDR_W-1:0];
            wdata_reg     <= req_wdata;
            cnt_reg       <= 4'(LATENCY - 1);
            state_reg     <= WAIT;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            // Stores and rejected accesses answer with zero data.
            rsp_rdata_reg <= (we_reg || err_reg) ? '0 : mem[addr_reg];
            rsp_we_reg    <= we_reg;
            rsp_err_reg   <= err_reg;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign busy      = busy_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_we    = rsp_we_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench for dmem_controller: latency, backpressure, range errors,
// mid-access reset and back-to-back acceptance spacing.
module tb_dmem_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_we;
  logic        rsp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_controller #(.ADDR_W(8), .DATA_W(16), .LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_we    (rsp_we),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full request/response with rsp_ready raised as soon as the response appears.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                     output logic [15:0] rd, output logic er, output logic rw, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 16'hFFFF;
    req_wdata = 16'hDEAD;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rw = rsp_we;
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("ready_after_hs", 32'(req_ready), 32'd1);
    $display("[TB] txn we=%0d addr=%04h wdata=%04h -> rdata=%04h err=%0d we=%0d lat=%0d",
             we, addr, wd, rd, er, rw, lat);
  endtask

  logic [15:0] rd;
  logic        er;
  logic        rw;
  int          lat;
  int          gap;
  logic [15:0] held;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 16'h0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_we",    32'(rsp_we),    32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Load of untouched address reads zero.
    txn(1'b0, 16'h0007, 16'h0, rd, er, rw, lat);
    check("ld7_rdata", 32'(rd), 32'h0);
    check("ld7_err",   32'(er), 32'd0);

    // Store latency and acknowledge contents.
    txn(1'b1, 16'h0005, 16'hBEEF, rd, er, rw, lat);
    check("st5_lat",   32'(lat), 32'd2);
    check("st5_we",    32'(rw),  32'd1);
    check("st5_err",   32'(er),  32'd0);
    check("st5_rdata", 32'(rd),  32'h0);

    txn(1'b0, 16'h0005, 16'h0, rd, er, rw, lat);
    check("ld5_rdata", 32'(rd),  32'hBEEF);
    check("ld5_we",    32'(rw),  32'd0);
    check("ld5_lat",   32'(lat), 32'd2);

    // Backpressure: response held for 5 cycles with rsp_ready low.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0005;
    @(posedge clk);
    #1;
    req_addr  = 16'h0007;
    req_we    = 1'b1;
    req_wdata = 16'h5555;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("bp_lat", 32'(lat), 32'd2);
    held = rsp_rdata;
    check("bp_rdata", 32'(held), 32'hBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_rdata_hold", 32'(rsp_rdata), 32'(held));
      check("bp_ready_low",  32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_ready_after", 32'(req_ready), 32'd1);
    check("bp_valid_after", 32'(rsp_valid), 32'd0);
    $display("[TB] txn backpressured load addr=0005 -> rdata=%04h", held);

    // Request inputs changed while busy must not have stored 0x5555 at 7.
    txn(1'b0, 16'h0007, 16'h0, rd, er, rw, lat);
    check("ignored_busy_st", 32'(rd), 32'h0);

    // Out-of-range accesses.
    txn(1'b1, 16'h0100, 16'h1234, rd, er, rw, lat);
    check("oor_st_err",   32'(er), 32'd1);
    check("oor_st_rdata", 32'(rd), 32'h0);
    check("oor_st_we",    32'(rw), 32'd1);
    txn(1'b0, 16'h0000, 16'h0, rd, er, rw, lat);
    check("oor_alias0", 32'(rd), 32'h0);
    check("oor_ld0_err", 32'(er), 32'd0);
    txn(1'b0, 16'h0105, 16'h0, rd, er, rw, lat);
    check("oor_ld_err",   32'(er), 32'd1);
    check("oor_ld_rdata", 32'(rd), 32'h0);

    // Leave BEEF in the response register, then reset during a store's WAIT.
    txn(1'b0, 16'h0005, 16'h0, rd, er, rw, lat);
    check("pre_rst_ld5", 32'(rd), 32'hBEEF);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0003;
    req_wdata = 16'hAAAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_req_ready", 32'(req_ready), 32'd1);
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_busy",      32'(busy),      32'd0);
    check("mr_rsp_rdata", 32'(rsp_rdata), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] txn store addr=0003 wdata=aaaa aborted by reset");
    txn(1'b0, 16'h0003, 16'h0, rd, er, rw, lat);
    check("mr_ld3", 32'(rd), 32'h0);
    txn(1'b0, 16'h0005, 16'h0, rd, er, rw, lat);
    check("mr_ld5_cleared", 32'(rd), 32'h0);

    // Back-to-back stores with req_valid held and rsp_ready tied high.
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr  = 16'(k + 1);
      req_wdata = 16'((k + 1) * 16'h11);
      @(posedge clk);
      gap = 1;
      @(negedge clk);
      while (!req_ready && gap < 50) begin
        @(negedge clk);
        gap++;
      end
      if (k < 2) check("b2b_gap", 32'(gap), 32'd4);
      $display("[TB] txn b2b store addr=%04h wdata=%04h gap=%0d", 16'(k + 1), 16'(k + 1) * 16'h11, gap);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      txn(1'b0, 16'(k + 1), 16'h0, rd, er, rw, lat);
      check("b2b_ld", 32'(rd), 32'((k + 1) * 16'h11));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
